umi_address_remap_cfg: RTL and testbench

- UMI device-side register block that owns the configuration of the address remap stage.
- Decodes single-beat UMI read, write and posted requests and holds NMAPS old/new chip-ID pairs plus the offset window (low/high/offset).
- Drives these registers directly into the remap stage's configuration inputs.
- Returns UMI responses through a one-entry registered response buffer.

---
 rtl/remap_cfg_pkg.sv | 10 +
 rtl/umi_pkg.sv | 28 ++
 rtl/umi_address_remap_cfg_if.sv | 31 +++
 rtl/umi_resp_buf.sv | 61 ++++++
 rtl/umi_address_remap_cfg.sv | 137 +++++++++++++
 tb/tb_umi_address_remap_cfg.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/remap_cfg_pkg.sv
// Register byte offsets of the address remap configuration block.
package remap_cfg_pkg;

  localparam int REMAP_OLD_BASE = 'h00;
  localparam int REMAP_NEW_BASE = 'h40;
  localparam int REMAP_LOW      = 'h80;
  localparam int REMAP_HIGH     = 'h88;
  localparam int REMAP_OFFSET   = 'h90;

endpackage

// File: rtl/umi_pkg.sv
// UMI protocol constants shared by device-side register blocks:
// opcodes, command field positions, error codes and response buffer states.
package umi_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

  localparam int UMI_OP_LSB   = 0;
  localparam int UMI_OP_MSB   = 4;
  localparam int UMI_SIZE_LSB = 5;
  localparam int UMI_SIZE_MSB = 7;
  localparam int UMI_LEN_LSB  = 8;
  localparam int UMI_LEN_MSB  = 15;
  localparam int UMI_ERR_LSB  = 25;
  localparam int UMI_ERR_MSB  = 26;

  localparam logic [1:0] UMI_ERR_OK  = 2'b00;
  localparam logic [1:0] UMI_ERR_DEV = 2'b10;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } resp_buf_state_e;

endpackage

// File: rtl/umi_address_remap_cfg_if.sv
// UMI device port bundle: request channel in, response channel out.
interface umi_address_remap_cfg_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) ();

  logic          req_valid;
  logic [CW-1:0] req_cmd;
  logic [AW-1:0] req_dstaddr;
  logic [AW-1:0] req_srcaddr;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          resp_valid;
  logic [CW-1:0] resp_cmd;
  logic [AW-1:0] resp_dstaddr;
  logic [AW-1:0] resp_srcaddr;
  logic [DW-1:0] resp_data;
  logic          resp_ready;

  modport master (
    output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
    output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
  );

endinterface

// File: rtl/umi_resp_buf.sv
// One-entry registered UMI response holder; a new response may be loaded
// in the same cycle the held one is consumed, so throughput is one per cycle.
module umi_resp_buf
  import umi_pkg::*;
#(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] in_cmd,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_cmd,
  output logic [AW-1:0] out_dstaddr,
  output logic [AW-1:0] out_srcaddr,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  resp_buf_state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BUF_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (load) state_d = BUF_FULL;
      BUF_FULL:  if (load) state_d = BUF_FULL;
                 else if (out_ready) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  assign out_valid = (state_q == BUF_FULL);
  assign in_ready  = ~out_valid | out_ready;

  // load only happens when in_ready, so a held response is never overwritten
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cmd     <= '0;
      out_dstaddr <= '0;
      out_srcaddr <= '0;
      out_data    <= '0;
    end else if (load) begin
      out_cmd     <= in_cmd;
      out_dstaddr <= in_dstaddr;
      out_srcaddr <= in_srcaddr;
      out_data    <= in_data;
    end
  end

endmodule

// File: rtl/umi_address_remap_cfg.sv
// UMI register block holding the chip-ID remap pairs and the offset window
// that feed the address remap stage.
module umi_address_remap_cfg
  import umi_pkg::*;
  import remap_cfg_pkg::*;
#(
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int DW    = 128,
  parameter int IDW   = 16,
  parameter int NMAPS = 8,
  parameter int RAW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  umi_address_remap_cfg_if.slave udev,
  output logic [IDW*NMAPS-1:0] old_row_col_address,
  output logic [IDW*NMAPS-1:0] new_row_col_address,
  output logic [AW-1:0]        set_dstaddress_low,
  output logic [AW-1:0]        set_dstaddress_high,
  output logic [AW-1:0]        set_dstaddress_offset
);

  localparam logic [RAW-1:0] OFF_LOW    = RAW'(REMAP_LOW);
  localparam logic [RAW-1:0] OFF_HIGH   = RAW'(REMAP_HIGH);
  localparam logic [RAW-1:0] OFF_OFFSET = RAW'(REMAP_OFFSET);

  logic [4:0]     opcode;
  logic [2:0]     size;
  logic [7:0]     len;
  logic [RAW-1:0] off;
  logic           req_ready_int;
  logic           accept;
  logic           legal;
  logic           do_write;
  logic           has_resp;
  logic [1:0]     err;
  logic [CW-1:0]  rsp_cmd;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  rsp_data;
  logic           unused_req;

  logic [IDW-1:0] old_q [NMAPS];
  logic [IDW-1:0] new_q [NMAPS];
  logic [AW-1:0]  low_q;
  logic [AW-1:0]  high_q;
  logic [AW-1:0]  offset_q;

  assign opcode = udev.req_cmd[UMI_OP_MSB:UMI_OP_LSB];
  assign size   = udev.req_cmd[UMI_SIZE_MSB:UMI_SIZE_LSB];
  assign len    = udev.req_cmd[UMI_LEN_MSB:UMI_LEN_LSB];
  assign off    = udev.req_dstaddr[RAW-1:0];

  // only single 8-byte aligned beats are legal register accesses
  assign legal    = (size == 3'd3) && (len == 8'd0) && (udev.req_dstaddr[2:0] == 3'b000);
  assign accept   = udev.req_valid & req_ready_int;
  assign do_write = accept & legal & ((opcode == UMI_REQ_WRITE) | (opcode == UMI_REQ_POSTED));
  assign has_resp = accept & ((opcode == UMI_REQ_READ) | (opcode == UMI_REQ_WRITE));
  assign udev.req_ready = req_ready_int;

  // unmapped offsets read back as zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NMAPS; i++) begin
      if (off == RAW'(REMAP_OLD_BASE + 8 * i)) rd_data[IDW-1:0] = old_q[i];
      if (off == RAW'(REMAP_NEW_BASE + 8 * i)) rd_data[IDW-1:0] = new_q[i];
    end
    if (off == OFF_LOW)    rd_data[AW-1:0] = low_q;
    if (off == OFF_HIGH)   rd_data[AW-1:0] = high_q;
    if (off == OFF_OFFSET) rd_data[AW-1:0] = offset_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NMAPS; i++) begin
        old_q[i] <= '0;
        new_q[i] <= '0;
      end
      low_q    <= '1;
      high_q   <= '0;
      offset_q <= '0;
    end else if (do_write) begin
      for (int i = 0; i < NMAPS; i++) begin
        if (off == RAW'(REMAP_OLD_BASE + 8 * i)) old_q[i] <= udev.req_data[IDW-1:0];
        if (off == RAW'(REMAP_NEW_BASE + 8 * i)) new_q[i] <= udev.req_data[IDW-1:0];
      end
      if (off == OFF_LOW)    low_q    <= udev.req_data[AW-1:0];
      if (off == OFF_HIGH)   high_q   <= udev.req_data[AW-1:0];
      if (off == OFF_OFFSET) offset_q <= udev.req_data[AW-1:0];
    end
  end

  always_comb begin
    err     = legal ? UMI_ERR_OK : UMI_ERR_DEV;
    rsp_cmd = udev.req_cmd;
    rsp_cmd[UMI_OP_MSB:UMI_OP_LSB]   = (opcode == UMI_REQ_READ) ? UMI_RESP_READ : UMI_RESP_WRITE;
    rsp_cmd[UMI_ERR_MSB:UMI_ERR_LSB] = err;
    rsp_data = ((opcode == UMI_REQ_READ) && legal) ? rd_data : '0;
  end

  always_comb begin
    old_row_col_address = '0;
    new_row_col_address = '0;
    for (int i = 0; i < NMAPS; i++) begin
      old_row_col_address[IDW*i +: IDW] = old_q[i];
      new_row_col_address[IDW*i +: IDW] = new_q[i];
    end
  end

  assign set_dstaddress_low    = low_q;
  assign set_dstaddress_high   = high_q;
  assign set_dstaddress_offset = offset_q;

  assign unused_req = ^{udev.req_dstaddr, udev.req_data, udev.req_cmd};

  umi_resp_buf #(
    .CW (CW),
    .AW (AW),
    .DW (DW)
  ) u_resp_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (has_resp),
    .in_cmd      (rsp_cmd),
    .in_dstaddr  (udev.req_srcaddr),
    .in_srcaddr  (udev.req_dstaddr),
    .in_data     (rsp_data),
    .in_ready    (req_ready_int),
    .out_valid   (udev.resp_valid),
    .out_cmd     (udev.resp_cmd),
    .out_dstaddr (udev.resp_dstaddr),
    .out_srcaddr (udev.resp_srcaddr),
    .out_data    (udev.resp_data),
    .out_ready   (udev.resp_ready)
  );

endmodule

// File: tb/tb_umi_address_remap_cfg.sv
// Directed bench for the UMI address remap configuration register block.
module tb_umi_address_remap_cfg;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] old_ids, new_ids;
  logic [63:0]  low, high, offset;
  int tests = 0;
  int fails = 0;

  umi_address_remap_cfg_if #(.CW(32), .AW(64), .DW(128)) udev ();

  umi_address_remap_cfg #(
    .CW(32), .AW(64), .DW(128), .IDW(16), .NMAPS(8), .RAW(8)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .udev                  (udev),
    .old_row_col_address   (old_ids),
    .new_row_col_address   (new_ids),
    .set_dstaddress_low    (low),
    .set_dstaddress_high   (high),
    .set_dstaddress_offset (offset)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] CMD_RD_OK  = 32'h0000_0062;
  localparam logic [31:0] CMD_WR_OK  = 32'h0000_0064;
  localparam logic [31:0] CMD_RD_ERR = 32'h0400_0062;
  localparam logic [31:0] CMD_WR_ERR = 32'h0400_0044;

  function automatic logic [63:0] src_of(input logic [63:0] addr);
    return 64'hCAFE_0000_0000_0000 | addr;
  endfunction

  task automatic set_req(input logic [4:0] op, input logic [63:0] addr, input logic [127:0] data,
                         input logic [2:0] size, input logic [7:0] len);
    udev.req_cmd     = {16'h0, len, size, op};
    udev.req_dstaddr = addr;
    udev.req_srcaddr = src_of(addr);
    udev.req_data    = data;
    udev.req_valid   = 1'b1;
  endtask

  // returns 1 ns after the handshake edge
  task automatic drive_req(input logic [4:0] op, input logic [63:0] addr, input logic [127:0] data,
                           input logic [2:0] size = 3'd3, input logic [7:0] len = 8'd0);
    int n = 0;
    set_req(op, addr, data, size, len);
    while (!udev.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL handshake_timeout addr=%h: req_ready stayed %b, required 1", addr, udev.req_ready);
    end
    @(posedge clk);
    #1;
    udev.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (udev.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got=%b exp=0", udev.resp_valid); end
    tests++; if (udev.resp_cmd !== 32'h0) begin fails++; $display("FAIL rst_resp_cmd got=%h exp=0", udev.resp_cmd); end
    tests++; if (udev.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got=%b exp=1", udev.req_ready); end
    tests++; if (low !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL rst_low got=%h exp=all ones", low); end
    tests++; if (high !== 64'h0 || offset !== 64'h0) begin fails++; $display("FAIL rst_high_offset got=%h/%h exp=0/0", high, offset); end
    tests++; if (old_ids !== 128'h0 || new_ids !== 128'h0) begin fails++; $display("FAIL rst_ids got=%h/%h exp=0/0", old_ids, new_ids); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_reads;
    drive_req(5'h01, 64'h80, 128'h0);
    tests++; if (udev.resp_valid !== 1'b1) begin fails++; $display("FAIL rd_low valid got=%b exp=1", udev.resp_valid); end
    tests++; if (udev.resp_cmd !== CMD_RD_OK) begin fails++; $display("FAIL rd_low cmd got=%h exp=%h", udev.resp_cmd, CMD_RD_OK); end
    tests++; if (udev.resp_data !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL rd_low data got=%h exp=ffffffffffffffff", udev.resp_data); end
    tests++; if (udev.resp_dstaddr !== 64'hCAFE_0000_0000_0080) begin fails++; $display("FAIL rd_low dstaddr got=%h exp=cafe000000000080", udev.resp_dstaddr); end
    tests++; if (udev.resp_srcaddr !== 64'h80) begin fails++; $display("FAIL rd_low srcaddr got=%h exp=80", udev.resp_srcaddr); end
    drive_req(5'h01, 64'h88, 128'h0);
    tests++; if (udev.resp_valid !== 1'b1 || udev.resp_data !== 128'h0) begin fails++; $display("FAIL rd_high got v=%b d=%h exp v=1 d=0", udev.resp_valid, udev.resp_data); end
  endtask

  task automatic test_write_map;
    drive_req(5'h03, 64'h00, 128'h0005);
    tests++; if (udev.resp_valid !== 1'b1 || udev.resp_cmd !== CMD_WR_OK) begin fails++; $display("FAIL wr_old0 resp got v=%b cmd=%h exp v=1 cmd=%h", udev.resp_valid, udev.resp_cmd, CMD_WR_OK); end
    tests++; if (old_ids[15:0] !== 16'h0005) begin fails++; $display("FAIL wr_old0 reg got=%h exp=0005", old_ids[15:0]); end
    drive_req(5'h03, 64'h40, 128'h0009);
    tests++; if (udev.resp_cmd !== CMD_WR_OK) begin fails++; $display("FAIL wr_new0 cmd got=%h exp=%h", udev.resp_cmd, CMD_WR_OK); end
    tests++; if (new_ids[15:0] !== 16'h0009) begin fails++; $display("FAIL wr_new0 reg got=%h exp=0009", new_ids[15:0]); end
    drive_req(5'h03, 64'h18, 128'hBEEF);
    tests++; if (old_ids[63:48] !== 16'hBEEF || old_ids[15:0] !== 16'h0005) begin fails++; $display("FAIL wr_old3 got=%h exp=beef...0005", old_ids[63:0]); end
    drive_req(5'h03, 64'h80, 128'h100);
    drive_req(5'h03, 64'h88, 128'h200);
    tests++; if (low !== 64'h100 || high !== 64'h200) begin fails++; $display("FAIL wr_window got=%h/%h exp=100/200", low, high); end
    drive_req(5'h03, 64'h00, 128'h1_2345);
    tests++; if (old_ids[15:0] !== 16'h2345) begin fails++; $display("FAIL wr_trunc got=%h exp=2345", old_ids[15:0]); end
  endtask

  task automatic test_posted;
    drive_req(5'h05, 64'h90, 128'h1000);
    tests++; if (udev.resp_valid !== 1'b0) begin fails++; $display("FAIL posted resp_valid got=%b exp=0", udev.resp_valid); end
    tests++; if (offset !== 64'h1000) begin fails++; $display("FAIL posted offset got=%h exp=1000", offset); end
    drive_req(5'h01, 64'h90, 128'h0);
    tests++; if (udev.resp_data !== 128'h1000 || udev.resp_cmd !== CMD_RD_OK) begin fails++; $display("FAIL rd_offset got d=%h c=%h exp d=1000 c=%h", udev.resp_data, udev.resp_cmd, CMD_RD_OK); end
    drive_req(5'h03, 64'h88, 128'h5555);
    drive_req(5'h01, 64'h88, 128'h0);
    tests++; if (udev.resp_data !== 128'h5555) begin fails++; $display("FAIL raw_b2b got=%h exp=5555", udev.resp_data); end
  endtask

  task automatic test_illegal;
    drive_req(5'h03, 64'h38, 128'hFFFF, 3'd2);
    tests++; if (udev.resp_valid !== 1'b1 || udev.resp_cmd !== CMD_WR_ERR) begin fails++; $display("FAIL ill_wr cmd got v=%b c=%h exp v=1 c=%h", udev.resp_valid, udev.resp_cmd, CMD_WR_ERR); end
    tests++; if (old_ids[127:112] !== 16'h0) begin fails++; $display("FAIL ill_wr old7 got=%h exp=0", old_ids[127:112]); end
    drive_req(5'h01, 64'h84, 128'h0);
    tests++; if (udev.resp_cmd !== CMD_RD_ERR || udev.resp_data !== 128'h0) begin fails++; $display("FAIL ill_rd got c=%h d=%h exp c=%h d=0", udev.resp_cmd, udev.resp_data, CMD_RD_ERR); end
    drive_req(5'h05, 64'h80, 128'h7777, 3'd3, 8'd1);
    tests++; if (udev.resp_valid !== 1'b0 || low !== 64'h100) begin fails++; $display("FAIL ill_posted got v=%b low=%h exp v=0 low=100", udev.resp_valid, low); end
    drive_req(5'h03, 64'hA0, 128'h1234);
    tests++; if (udev.resp_cmd !== CMD_WR_OK) begin fails++; $display("FAIL unmapped_wr cmd got=%h exp=%h", udev.resp_cmd, CMD_WR_OK); end
    drive_req(5'h01, 64'hA0, 128'h0);
    tests++; if (udev.resp_cmd !== CMD_RD_OK || udev.resp_data !== 128'h0) begin fails++; $display("FAIL unmapped_rd got c=%h d=%h exp c=%h d=0", udev.resp_cmd, udev.resp_data, CMD_RD_OK); end
    drive_req(5'h02, 64'h80, 128'h0);
    tests++; if (udev.resp_valid !== 1'b0) begin fails++; $display("FAIL other_op resp_valid got=%b exp=0", udev.resp_valid); end
  endtask

  task automatic test_back_to_back;
    repeat (2) @(negedge clk);
    udev.resp_ready = 1'b0;
    drive_req(5'h01, 64'h00, 128'h0);
    tests++; if (udev.resp_valid !== 1'b1 || udev.resp_data !== 128'h2345) begin fails++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=2345", udev.resp_valid, udev.resp_data); end
    set_req(5'h01, 64'h40, 128'h0, 3'd3, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (udev.req_ready !== 1'b0 || udev.resp_valid !== 1'b1 || udev.resp_data !== 128'h2345 ||
          udev.resp_srcaddr !== 64'h0 || udev.resp_cmd !== CMD_RD_OK) begin
        fails++;
        $display("FAIL bp_hold cyc%0d got rdy=%b v=%b d=%h s=%h c=%h exp rdy=0 v=1 d=2345 s=0 c=%h",
                 i, udev.req_ready, udev.resp_valid, udev.resp_data, udev.resp_srcaddr, udev.resp_cmd, CMD_RD_OK);
      end
    end
    udev.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    udev.req_valid = 1'b0;
    tests++; if (udev.resp_valid !== 1'b1 || udev.resp_data !== 128'h9 || udev.resp_srcaddr !== 64'h40) begin fails++; $display("FAIL bp_next got v=%b d=%h s=%h exp v=1 d=9 s=40", udev.resp_valid, udev.resp_data, udev.resp_srcaddr); end
    @(posedge clk);
    #1;
    tests++; if (udev.resp_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", udev.resp_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    udev.resp_ready = 1'b0;
    drive_req(5'h01, 64'h80, 128'h0);
    tests++; if (udev.resp_valid !== 1'b1) begin fails++; $display("FAIL mid_pending got=%b exp=1", udev.resp_valid); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (udev.resp_valid !== 1'b0 || udev.req_ready !== 1'b1) begin fails++; $display("FAIL mid_resp got v=%b rdy=%b exp v=0 rdy=1", udev.resp_valid, udev.req_ready); end
    tests++; if (low !== 64'hFFFF_FFFF_FFFF_FFFF || high !== 64'h0 || offset !== 64'h0) begin fails++; $display("FAIL mid_window got %h/%h/%h exp ones/0/0", low, high, offset); end
    tests++; if (old_ids !== 128'h0 || new_ids !== 128'h0) begin fails++; $display("FAIL mid_ids got %h/%h exp 0/0", old_ids, new_ids); end
    @(negedge clk);
    reset = 1'b0;
    udev.resp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    udev.req_valid   = 1'b0;
    udev.req_cmd     = '0;
    udev.req_dstaddr = '0;
    udev.req_srcaddr = '0;
    udev.req_data    = '0;
    udev.resp_ready  = 1'b1;
    test_reset;
    test_reset_reads;
    test_write_map;
    test_posted;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
